// File: rtl/eq_param_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : eq_pkg                                                   |
// | Function  : Shared types and helpers for the equaliser UI controller |
// |             (top FSM states, menu cursor values, saturating step).   |
// | Revision  : 1.0 - initial parametrised release                       |
// +----------------------------------------------------------------------+
package eq_pkg;

   // Top-level controller states; encodings are visible on o_state.
   typedef enum logic [2:0] {
      INIT       = 3'd0,
      IDLE       = 3'd1,
      MENU       = 3'd2,
      BAND_SEL   = 3'd3,
      SET_GAIN   = 3'd4,
      SET_OFFSET = 3'd5,
      RESET_DSP  = 3'd6,
      COMMIT     = 3'd7
   } state_e;

   // Menu cursor positions.
   typedef enum logic [1:0] {
      EQ     = 2'd0,
      OFFSET = 2'd1,
      RESET  = 2'd2
   } menu_e;

   // One +/-1 step of a signed value with saturation. The sum is formed one
   // bit wider than the operand so it can never wrap before clamping; the
   // caller narrows the result to its gain width (always in range).
   function automatic logic signed [31:0] sat_step(
      input logic signed [31:0] value,
      input logic               dir,      // 1 = increment, 0 = decrement
      input logic signed [31:0] min_v,
      input logic signed [31:0] max_v
   );
      logic signed [32:0] sum;
      if (dir) sum = 33'(value) + 33'sd1;
      else     sum = 33'(value) - 33'sd1;
      if (sum > 33'(max_v))      return max_v;
      else if (sum < 33'(min_v)) return min_v;
      else                       return sum[31:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/eq_param_ctrl_cfg_tx_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : cfg_tx_reg                                               |
// | Function  : Valid/ready holding register for one config beat. A load |
// |             raises valid and captures the payload; both stay stable  |
// |             until the cycle ready is seen (the transfer).            |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module cfg_tx_reg #(
   parameter int BAND_W = 3,
   parameter int GAIN_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_load,
   input  logic [BAND_W-1:0] i_band,
   input  logic [GAIN_W-1:0] i_gain,
   input  logic              i_ready,
   output logic              o_valid,
   output logic [BAND_W-1:0] o_band,
   output logic [GAIN_W-1:0] o_gain,
   output logic              o_done
);

   logic              r_valid;
   logic [BAND_W-1:0] r_band;
   logic [GAIN_W-1:0] r_gain;

   // Capture a beat on load; drop valid after the transfer cycle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_band  <= '0;
         r_gain  <= '0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_band  <= i_band;
         r_gain  <= i_gain;
      end else if (r_valid && i_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_band  = r_band;
   assign o_gain  = r_gain;
   assign o_done  = r_valid & i_ready;

endmodule
`default_nettype wire

// File: rtl/eq_param_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : eq_param_ctrl                                            |
// | Function  : Equaliser UI controller. Menu FSM driven by button       |
// |             pulses, per-band signed gains with cancel, global offset |
// |             and a valid/ready config channel towards the DSP.        |
// | Options   : EQ_PARAM_CTRL_LIVE_PREVIEW_EN - send a config beat on    |
// |             every effective gain step and on cancel.                 |
// | Revision  : 1.0 - initial parametrised release                       |
// +----------------------------------------------------------------------+
module eq_param_ctrl
   import eq_pkg::*;
#(
   parameter  int N_BANDS    = 6,
   parameter  int GAIN_W     = 16,
   parameter  int GAIN_MAX   = 12,
   parameter  int GAIN_MIN   = -12,
   parameter  int OFFSET_W   = 3,
   parameter  int OFFSET_MAX = 3,
   localparam int BAND_W     = $clog2(N_BANDS)
) (
   input  logic                       i_clk,
   input  logic                       i_rst,
   input  logic                       i_init_done,
   input  logic                       i_select,
   input  logic                       i_back,
   input  logic                       i_up,
   input  logic                       i_down,
   input  logic                       i_cfg_ready,
   output logic                       o_init_start,
   output logic [2:0]                 o_state,
   output logic [1:0]                 o_menu,
   output logic [BAND_W-1:0]          o_band,
   output logic [GAIN_W-1:0]          o_gain,
   output logic [N_BANDS*GAIN_W-1:0]  o_gain_bus,
   output logic [OFFSET_W-1:0]        o_offset,
   output logic                       o_cfg_valid,
   output logic [BAND_W-1:0]          o_cfg_band,
   output logic [GAIN_W-1:0]          o_cfg_gain,
   output logic                       o_dsp_reset
);

   localparam logic [BAND_W-1:0]   c_band_last  = BAND_W'(N_BANDS - 1);
   localparam logic [OFFSET_W-1:0] c_offset_max = OFFSET_W'(OFFSET_MAX);

   state_e                    r_state,  w_state_nxt;
   menu_e                     r_menu,   w_menu_nxt;
   logic [BAND_W-1:0]         r_band,   w_band_nxt;
   logic [OFFSET_W-1:0]       r_offset, w_offset_nxt;
   logic signed [GAIN_W-1:0]  r_gain     [N_BANDS];
   logic signed [GAIN_W-1:0]  w_gain_nxt [N_BANDS];
   logic signed [GAIN_W-1:0]  r_backup, w_backup_nxt;
   logic signed [GAIN_W-1:0]  r_gain_sel;
   logic signed [GAIN_W-1:0]  w_step;
   logic                      r_init_start;
   logic                      r_dsp_reset;

   logic                      w_cfg_load;
   logic [BAND_W-1:0]         w_cfg_band_ld;
   logic [GAIN_W-1:0]         w_cfg_gain_ld;
   logic                      w_cfg_valid;
   logic                      w_cfg_done;

   // Selected band stepped by one in the direction of the winning button
   // (up beats down, so i_up alone picks the direction).
   assign w_step = GAIN_W'(sat_step(32'(r_gain[r_band]), i_up, GAIN_MIN, GAIN_MAX));

   // State, cursor, gains and offset register; derived outputs follow next-state.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= INIT;
         r_menu       <= EQ;
         r_band       <= '0;
         r_offset     <= '0;
         r_backup     <= '0;
         r_gain_sel   <= '0;
         r_init_start <= 1'b1;
         r_dsp_reset  <= 1'b0;
         for (int k = 0; k < N_BANDS; k++) r_gain[k] <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_menu       <= w_menu_nxt;
         r_band       <= w_band_nxt;
         r_offset     <= w_offset_nxt;
         r_backup     <= w_backup_nxt;
         r_gain_sel   <= w_gain_nxt[w_band_nxt];
         r_init_start <= (w_state_nxt == INIT);
         r_dsp_reset  <= (w_state_nxt == RESET_DSP);
         r_gain       <= w_gain_nxt;
      end
   end

   // Next-state and data-path decisions; back > select > up > down.
   always_comb begin
      w_state_nxt   = r_state;
      w_menu_nxt    = r_menu;
      w_band_nxt    = r_band;
      w_offset_nxt  = r_offset;
      w_backup_nxt  = r_backup;
      w_gain_nxt    = r_gain;
      w_cfg_load    = 1'b0;
      w_cfg_band_ld = r_band;
      w_cfg_gain_ld = r_gain[r_band];

      case (r_state)
         INIT: begin
            if (i_init_done) w_state_nxt = IDLE;
         end
         IDLE: begin
            if (i_select) begin
               w_state_nxt = MENU;
               w_menu_nxt  = EQ;
            end
         end
         MENU: begin
            if (i_back) begin
               w_state_nxt = IDLE;
            end else if (i_select) begin
               case (r_menu)
                  EQ: begin
                     w_state_nxt = BAND_SEL;
                     w_band_nxt  = '0;
                  end
                  OFFSET: w_state_nxt = SET_OFFSET;
                  RESET: begin
                     // Clearing happens on entry so the pulse cycle already
                     // shows zeroed gains alongside o_dsp_reset.
                     w_state_nxt  = RESET_DSP;
                     w_offset_nxt = '0;
                     for (int k = 0; k < N_BANDS; k++) w_gain_nxt[k] = '0;
                  end
                  default: w_state_nxt = MENU;
               endcase
            end else if (i_up) begin
               if (r_menu != RESET) w_menu_nxt = menu_e'(r_menu + 2'd1);
            end else if (i_down) begin
               if (r_menu != EQ) w_menu_nxt = menu_e'(r_menu - 2'd1);
            end
         end
         BAND_SEL: begin
            if (i_back) begin
               w_state_nxt = MENU;
            end else if (i_select) begin
               w_state_nxt  = SET_GAIN;
               w_backup_nxt = r_gain[r_band];
            end else if (i_up) begin
               if (r_band != c_band_last) w_band_nxt = r_band + 1'b1;
            end else if (i_down) begin
               if (r_band != '0) w_band_nxt = r_band - 1'b1;
            end
         end
         SET_GAIN: begin
`ifdef EQ_PARAM_CTRL_LIVE_PREVIEW_EN
            // While a preview beat is in flight every button is held off so
            // the payload on the channel is never overwritten.
            if (!w_cfg_valid) begin
               if (i_back) begin
                  w_gain_nxt[r_band] = r_backup;
                  w_cfg_load         = 1'b1;
                  w_cfg_gain_ld      = r_backup;
                  w_state_nxt        = BAND_SEL;
               end else if (i_select) begin
                  w_state_nxt = COMMIT;
                  w_cfg_load  = 1'b1;
               end else if (i_up || i_down) begin
                  w_gain_nxt[r_band] = w_step;
                  if (w_step != r_gain[r_band]) begin
                     w_cfg_load    = 1'b1;
                     w_cfg_gain_ld = w_step;
                  end
               end
            end
`else
            if (i_back) begin
               w_gain_nxt[r_band] = r_backup;
               w_state_nxt        = BAND_SEL;
            end else if (i_select) begin
               w_state_nxt = COMMIT;
               w_cfg_load  = 1'b1;
            end else if (i_up || i_down) begin
               w_gain_nxt[r_band] = w_step;
            end
`endif
         end
         SET_OFFSET: begin
            if (i_back || i_select) begin
               w_state_nxt = MENU;
            end else if (i_up) begin
               if (r_offset != '0) w_offset_nxt = r_offset - 1'b1;
            end else if (i_down) begin
               if (r_offset != c_offset_max) w_offset_nxt = r_offset + 1'b1;
            end
         end
         RESET_DSP: begin
            w_state_nxt = MENU;
         end
         COMMIT: begin
            if (w_cfg_done) w_state_nxt = BAND_SEL;
         end
         default: w_state_nxt = INIT;
      endcase
   end

   cfg_tx_reg #(
      .BAND_W (BAND_W),
      .GAIN_W (GAIN_W)
   ) u_cfg_tx (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_load  (w_cfg_load),
      .i_band  (w_cfg_band_ld),
      .i_gain  (w_cfg_gain_ld),
      .i_ready (i_cfg_ready),
      .o_valid (w_cfg_valid),
      .o_band  (o_cfg_band),
      .o_gain  (o_cfg_gain),
      .o_done  (w_cfg_done)
   );

   generate
      for (genvar k = 0; k < N_BANDS; k++) begin : g_bus
         assign o_gain_bus[k*GAIN_W +: GAIN_W] = r_gain[k];
      end
   endgenerate

   assign o_init_start = r_init_start;
   assign o_state      = r_state;
   assign o_menu       = r_menu;
   assign o_band       = r_band;
   assign o_gain       = r_gain_sel;
   assign o_offset     = r_offset;
   assign o_cfg_valid  = w_cfg_valid;
   assign o_dsp_reset  = r_dsp_reset;

endmodule
`default_nettype wire

// File: doc/eq_param_ctrl.md
Name: eq_param_ctrl

Overview:
User-interface controller for the equaliser. It turns debounced button pulses into a menu state machine and holds per-band signed gains and a global offset. It delivers gain updates to the DSP over a valid/ready config channel. It is the parametrised successor of the fixed 6-band top-level FSM: band count, gain width and gain limits are generic, gain edits can be cancelled, and the DSP interface is a handshake rather than a static level.

Parameters:
N_BANDS, 6, number of EQ bands (2..16); bands are indexed 0..N_BANDS-1.
GAIN_W, 16, width of a signed two's-complement gain word.
GAIN_MAX, 12, upper saturation limit for gain (signed).
GAIN_MIN, -12, lower saturation limit for gain (signed); GAIN_MIN < 0 < GAIN_MAX.
OFFSET_W, 3, width of the unsigned offset.
OFFSET_MAX, 3, maximum offset value.
BAND_W, $clog2(N_BANDS), derived width of the band index; not to be overridden.

Ports:
i_clk  in  1  system clock (BCLK domain)
i_rst  in  1  asynchronous, active-high reset
i_init_done  in  1  codec I2C initialisation finished (level)
i_select  in  1  select button, 1-cycle pulse
i_back  in  1  back button, 1-cycle pulse
i_up  in  1  up button, 1-cycle pulse
i_down  in  1  down button, 1-cycle pulse
i_cfg_ready  in  1  DSP accepts the config beat
o_init_start  out  1  start request to the I2C initialiser
o_state  out  3  current top FSM state encoding
o_menu  out  2  menu cursor: 0=EQ, 1=OFFSET, 2=RESET
o_band  out  BAND_W  selected band
o_gain  out  GAIN_W  gain of the selected band
o_gain_bus  out  N_BANDS*GAIN_W  all band gains; band k occupies bits [k*GAIN_W +: GAIN_W]
o_offset  out  OFFSET_W  current offset
o_cfg_valid  out  1  config beat valid
o_cfg_band  out  BAND_W  band carried by the config beat
o_cfg_gain  out  GAIN_W  gain carried by the config beat
o_dsp_reset  out  1  one-cycle DSP state clear

Behaviour:
- Reset values:
  - state=INIT, o_init_start=1.
  - menu=0, band=0, all gains=0, offset=0.
  - o_cfg_valid=0, o_cfg_band=0, o_cfg_gain=0, o_dsp_reset=0.
- Button priority in the same cycle: back > select > up > down. Only one action is taken per cycle.
- All outputs are registered. A state change is visible the cycle after the pulse.
- States and encodings:
  - INIT (0): o_init_start=1. On i_init_done go to IDLE and drop o_init_start.
  - IDLE (1): select -> MENU with menu=0.
  - MENU (2):
    - up increments menu, clamped at 2; down decrements, clamped at 0.
    - select: menu=0 -> BAND_SEL with band=0; menu=1 -> SET_OFFSET; menu=2 -> RESET_DSP.
    - back -> IDLE.
  - BAND_SEL (3):
    - up/down change band, clamped to 0..N_BANDS-1 (no wrap).
    - select -> SET_GAIN and latch the band's gain into a backup register.
    - back -> MENU.
  - SET_GAIN (4):
    - up/down change gain[band] by ±1, saturating at GAIN_MAX/GAIN_MIN.
    - select -> COMMIT.
    - back restores gain[band] from the backup, then -> BAND_SEL with no config beat.
  - SET_OFFSET (5):
    - down increments offset, up decrements it, clamped to 0..OFFSET_MAX.
    - select or back -> MENU.
    - A button pulse that also exits applies only the exit.
  - RESET_DSP (6):
    - For one cycle: o_dsp_reset=1, all gains=0, offset=0.
    - Then -> MENU.
    - No config beats are issued; the DSP clears its own gains on o_dsp_reset.
  - COMMIT (7):
    - On entry, o_cfg_valid=1 with o_cfg_band=band and o_cfg_gain=gain[band].
    - Valid and payload are held stable until the cycle i_cfg_ready=1. That cycle is the transfer.
    - After the transfer, o_cfg_valid=0 the next cycle and the FSM -> BAND_SEL.
    - All buttons are ignored while in COMMIT.
- If i_cfg_ready is already high on the first valid cycle, the transfer completes in 1 cycle and valid is high for exactly 1 cycle.
- Gain arithmetic is done at GAIN_W+1 bits before clamping, so it never wraps. Offset never wraps.
- Asynchronous reset mid-transaction drops o_cfg_valid immediately. The DSP must treat that as no transfer.

Optional Feature:
EQ_PARAM_CTRL_LIVE_PREVIEW_EN.
- Defined:
  - In SET_GAIN, every up/down that actually changes the gain issues a config beat with the new value, using the same hold-until-ready rule.
  - While a beat is outstanding, further up/down pulses are ignored.
  - back restores the backup and issues a beat carrying the restored value before returning to BAND_SEL.
  - select still goes through COMMIT.
- Undefined: config beats are issued only from COMMIT, as above.

Decomposition:
- Package eq_pkg holds:
  - state enum: INIT, IDLE, MENU, BAND_SEL, SET_GAIN, SET_OFFSET, RESET_DSP, COMMIT (3-bit, values 0..7);
  - menu enum: EQ, OFFSET, RESET (2-bit);
  - function sat_step(value, dir, min, max) returning a GAIN_W result.
- One sub-module, cfg_tx_reg: the valid/ready holding register (load, valid, payload, transfer-done output). It is shared by COMMIT and the preview path.

Test Plan:
- Init sequencing: reset, hold i_init_done=0 for 10 cycles -> state=0 and o_init_start=1. Pulse i_init_done -> state=1 and o_init_start=0 the next cycle.
- Gain saturation: N_BANDS=6; enter band 5 and press up 15 times -> o_gain=12. Press down 30 times -> o_gain=-12 (0xFFF4). No config beat is issued without the macro.
- Commit handshake: set band 2 gain to 3, press select, hold i_cfg_ready=0 for 5 cycles -> valid stays high with band=2, gain=3 stable. Raise ready -> one transfer, then state=BAND_SEL.
- Cancel: band 1 gain=4; enter SET_GAIN, press up twice (gain=6), press back -> gain=4 and zero config beats.
- Reset menu: gains {1,2,3,0,0,-1}, offset=2; select RESET -> o_dsp_reset high exactly 1 cycle, o_gain_bus=0, offset=0, state=MENU.
- Priority and clamping: back and up pulsed together in MENU -> state=IDLE with menu unchanged. Down at band 0 -> band stays 0. Async reset during COMMIT -> o_cfg_valid=0 immediately.
